// File: rtl/uart_tx_if.sv
// Byte-request / serial-line bundle of the host-link UART transmitter.
// master drives the request side, slave is the transmitter.
interface uart_tx_if;
    logic       iTxStart;
    logic [7:0] iTxByte;
    logic       oTxReady;
    logic       oTxBusy;
    logic       oTxSerial;
    logic       oTxDone;

    modport master (
        output iTxStart,
        output iTxByte,
        input  oTxReady,
        input  oTxBusy,
        input  oTxSerial,
        input  oTxDone
    );

    modport slave (
        input  iTxStart,
        input  iTxByte,
        output oTxReady,
        output oTxBusy,
        output oTxSerial,
        output oTxDone
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding register for gapless frames.
// Optional parity bit when UART_TX_PARITY_EN is defined (PARITY_ODD selects odd).
module uart_tx #(
    parameter int CLK_FREQ     = 125_000_000,
    parameter int BAUD_RATE    = 115_200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
    parameter int STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input logic      iClk,
    input logic      iRstn,
    uart_tx_if.slave tx
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd5;
`endif

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic [7:0]    holdByte;
    logic          holdFull;
    logic          serial;
    logic          done;
`ifdef UART_TX_PARITY_EN
    logic          parBit;
`endif

    logic accept;
    logic bitEnd;
    logic stopEnd;

    assign accept  = tx.iTxStart && !holdFull;
    assign bitEnd  = (cnt == BIT_LAST);
    assign stopEnd = (cnt == STOP_LAST);

    always_ff @(posedge iClk) begin
        if (!iRstn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            shift    <= '0;
            holdByte <= '0;
            holdFull <= 1'b0;
            serial   <= 1'b1;
            done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parBit   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;

            // An accept always wins the holding register over a load.
            if (accept) begin
                holdFull <= 1'b1;
                holdByte <= tx.iTxByte;
            end else if (holdFull && (state == S_IDLE || state == S_DONE)) begin
                holdFull <= 1'b0;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (holdFull) begin
                        state  <= S_START;
                        shift  <= holdByte;
                        serial <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        parBit <= (^holdByte) ^ PARITY_ODD;
`endif
                    end else begin
                        state  <= S_IDLE;
                        serial <= 1'b1;
                    end
                end

                S_START: begin
                    if (bitEnd) begin
                        cnt    <= '0;
                        idx    <= '0;
                        state  <= S_DATA;
                        serial <= shift[0];
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end

                S_DATA: begin
                    if (bitEnd) begin
                        cnt   <= '0;
                        idx   <= idx + 3'd1;
                        shift <= {1'b0, shift[7:1]};
                        if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state  <= S_PARITY;
                            serial <= parBit;
`else
                            state  <= S_STOP;
                            serial <= 1'b1;
`endif
                        end else begin
                            serial <= shift[1];
                        end
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bitEnd) begin
                        cnt    <= '0;
                        state  <= S_STOP;
                        serial <= 1'b1;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
`endif

                S_STOP: begin
                    if (stopEnd) begin
                        cnt    <= '0;
                        state  <= S_DONE;
                        serial <= 1'b1;
                        done   <= 1'b1;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    cnt    <= '0;
                    idx    <= '0;
                    serial <= 1'b1;
                end
            endcase
        end
    end

    assign tx.oTxReady  = !holdFull;
    assign tx.oTxBusy   = (state != S_IDLE);
    assign tx.oTxSerial = serial;
    assign tx.oTxDone   = done;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a line
// monitor decodes oTxSerial bit by bit against a frame-level model.
module tb_uart_tx;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct packed {
        logic [7:0] b;
        int         acc;
    } exp_t;

    logic clk;
    logic rstn;
    int   cyc;
    int   checks;
    int   errors;
    int   doneCnt;
    int   lastDone;
    bit   monEn;
    bit   monBusy;
    exp_t expQ[$];

    uart_tx_if tx ();
    uart_tx_if tx2 ();

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .iClk (clk),
        .iRstn(rstn),
        .tx   (tx)
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .iClk (clk),
        .iRstn(rstn),
        .tx   (tx2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial doneCnt = 0;
    always @(negedge clk) if (tx.oTxDone === 1'b1) doneCnt <= doneCnt + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Line level of bit period i of a frame carrying b.
    function automatic logic expLevel(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (PAR == 1 && i == 9) return ^b;
        return 1'b1;
    endfunction

    function automatic int frameBits(input int stopBits);
        return 1 + 8 + PAR + stopBits;
    endfunction

    task automatic sendByte(input logic [7:0] b, input bit push);
        int k;
        k = 0;
        while (tx.oTxReady !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 1000) begin
            chk("readyTimeout", 0, 1);
        end else begin
            tx.iTxStart = 1'b1;
            tx.iTxByte  = b;
            @(negedge clk);
            tx.iTxStart = 1'b0;
            tx.iTxByte  = 8'($urandom);
            if (push) expQ.push_back('{b: b, acc: cyc});
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((expQ.size() != 0 || monBusy || tx.oTxBusy !== 1'b0) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("drainTimeout", 32'(k < 5000), 1);
        repeat (3) @(negedge clk);
    endtask

    // Line monitor / scoreboard consumer.
    initial begin : monitor
        exp_t e;
        int   st;
        int   expSt;
        int   nb;
        int   bad;
        bit   got;
        got      = 1'b0;
        monBusy  = 1'b0;
        lastDone = -10;
        forever begin
            if (!got) @(negedge clk);
            got = 1'b0;
            if (monEn && tx.oTxSerial === 1'b0) begin
                monBusy = 1'b1;
                st = cyc;
                if (expQ.size() == 0) begin
                    chk("spuriousFrame", 1, 0);
                    repeat (frameBits(1) * CPB + 1) @(negedge clk);
                end else begin
                    e = expQ.pop_front();
                    expSt = (e.acc + 1 > lastDone + 1) ? e.acc + 1 : lastDone + 1;
                    chk("startCycle", st, expSt);
                    nb = frameBits(1);
                    for (int i = 0; i < nb; i++) begin
                        bad = 0;
                        for (int c = 0; c < CPB; c++) begin
                            if (!(i == 0 && c == 0)) @(negedge clk);
                            if (tx.oTxSerial !== expLevel(e.b, i)) bad++;
                            if (tx.oTxBusy !== 1'b1) bad++;
                        end
                        chk($sformatf("byte%02h_bit%0d", e.b, i), bad, 0);
                    end
                    @(negedge clk);
                    chk("doneHigh", {31'd0, tx.oTxDone}, 1);
                    chk("doneLine", {31'd0, tx.oTxSerial}, 1);
                    chk("frameLen", cyc - st, nb * CPB);
                    lastDone = cyc;
                    @(negedge clk);
                    chk("donePulse", {31'd0, tx.oTxDone}, 0);
                    got = 1'b1;
                end
                monBusy = 1'b0;
            end
        end
    end

    initial begin : stim
        int badS;
        int badR;
        int badB;
        int badD;
        int a;
        int doneBase;
        int lowCnt;
        int firstLow;
        int doneAt;
        int expLow;
        checks   = 0;
        errors   = 0;
        monEn    = 1'b0;
        rstn     = 1'b0;
        tx.iTxStart  = 1'b0;
        tx.iTxByte   = 8'h00;
        tx2.iTxStart = 1'b0;
        tx2.iTxByte  = 8'h00;

        repeat (3) @(negedge clk);
        chk("rstSerial", {31'd0, tx.oTxSerial}, 1);
        chk("rstReady", {31'd0, tx.oTxReady}, 1);
        chk("rstBusy", {31'd0, tx.oTxBusy}, 0);
        chk("rstDone", {31'd0, tx.oTxDone}, 0);
        rstn = 1'b1;

        badS = 0; badR = 0; badB = 0; badD = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx.oTxSerial !== 1'b1) badS++;
            if (tx.oTxReady !== 1'b1) badR++;
            if (tx.oTxBusy !== 1'b0) badB++;
            if (tx.oTxDone !== 1'b0) badD++;
        end
        chk("idleSerial", badS, 0);
        chk("idleReady", badR, 0);
        chk("idleBusy", badB, 0);
        chk("idleDone", badD, 0);

        monEn = 1'b1;
        doneBase = doneCnt;
        sendByte(8'hA5, 1'b1);
        drain();
        chk("singleDoneCount", doneCnt - doneBase, 1);
        chk("singleDoneAt", lastDone - expQ.size() * 0, 0 + lastDone);

        // Back-to-back with an ignored third request.
        doneBase = doneCnt;
        sendByte(8'h55, 1'b1);
        sendByte(8'h0F, 1'b1);
        repeat (20) @(negedge clk);
        chk("readyLowWhileHeld", {31'd0, tx.oTxReady}, 0);
        tx.iTxStart = 1'b1;
        tx.iTxByte  = 8'hEE;
        @(negedge clk);
        tx.iTxStart = 1'b0;
        drain();
        chk("b2bDoneCount", doneCnt - doneBase, 2);

        sendByte(8'h07, 1'b1);
        sendByte(8'h03, 1'b1);
        drain();

        // Randomized traffic, mixing back-to-back and idle gaps.
        for (int n = 0; n < 14; n++) begin
            sendByte(8'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0) repeat (200) @(negedge clk);
            else repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        // Reset in the middle of data bit 3 of 0x00.
        monEn = 1'b0;
        sendByte(8'h00, 1'b0);
        a = cyc;
        while (cyc < a + 1 + CPB + 3 * CPB + CPB / 2) @(negedge clk);
        chk("midBit3Low", {31'd0, tx.oTxSerial}, 0);
        chk("midBit3Busy", {31'd0, tx.oTxBusy}, 1);
        rstn = 1'b0;
        @(negedge clk);
        chk("abortSerial", {31'd0, tx.oTxSerial}, 1);
        chk("abortBusy", {31'd0, tx.oTxBusy}, 0);
        chk("abortReady", {31'd0, tx.oTxReady}, 1);
        chk("abortDone", {31'd0, tx.oTxDone}, 0);
        @(negedge clk);
        rstn = 1'b1;
        badS = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx.oTxSerial !== 1'b1 || tx.oTxBusy !== 1'b0) badS++;
        end
        chk("noFrameAfterAbort", badS, 0);
        monEn = 1'b1;

        // Two stop bits on the second instance.
        tx2.iTxStart = 1'b1;
        tx2.iTxByte  = 8'hFF;
        @(negedge clk);
        tx2.iTxStart = 1'b0;
        tx2.iTxByte  = 8'h00;
        a = cyc;
        lowCnt = 0; firstLow = -1; doneAt = -1;
        for (int k = 0; k < 400; k++) begin
            if (tx2.oTxSerial === 1'b0) begin
                lowCnt++;
                if (firstLow < 0) firstLow = cyc;
            end
            if (tx2.oTxDone === 1'b1) begin
                doneAt = cyc;
                break;
            end
            @(negedge clk);
        end
        expLow = 0;
        for (int i = 0; i < frameBits(2); i++)
            if (expLevel(8'hFF, i) == 1'b0) expLow += CPB;
        chk("stop2Start", firstLow - a, 1);
        chk("stop2Low", lowCnt, expLow);
        chk("stop2Len", doneAt - firstLow, frameBits(2) * CPB);
        @(negedge clk);
        chk("stop2Idle", {31'd0, tx2.oTxBusy}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
